// File: rtl/dmem_xbar.sv
// dmem_xbar: window-decoded data-memory crossbar with registered read-return mux and decode-fault tracking.
// Optional fault-address capture is enabled by defining DMEM_XBAR_FAULT_CAPTURE_EN.
module dmem_xbar #(
    parameter int                        N_SLAVES       = 3,
    parameter logic [N_SLAVES*32-1:0]    SLAVE_BASE     = {32'h20000000, 32'h10010000, 32'h08000000},
    parameter logic [N_SLAVES*32-1:0]    SLAVE_SIZE     = {32'h00000100, 32'h00001000, 32'h00001000},
    parameter logic [31:0]               UNMAPPED_RDATA = 32'hDEADBEEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [31:0]                  io_addr,
    input  logic                         io_ren,
    input  logic                         io_op,
    input  logic [3:0]                   io_mask,
    input  logic [31:0]                  io_wdata,
    output logic [31:0]                  io_rdata,
    output logic [N_SLAVES*32-1:0]       s_addr,
    output logic [N_SLAVES-1:0]          s_op,
    output logic [3:0]                   s_mask,
    output logic [31:0]                  s_wdata,
    input  logic [N_SLAVES*32-1:0]       s_rdata,
    output logic                         io_fault,
    output logic [7:0]                   io_fault_count,
    input  logic                         io_fault_clr,
    output logic [31:0]                  io_fault_addr,
    output logic                         io_fault_valid
);

    localparam int SEL_W = $clog2(N_SLAVES + 1);
    localparam logic [SEL_W-1:0] SEL_NONE = SEL_W'(N_SLAVES);

    logic [SEL_W-1:0] w_sel;
    logic             w_fault;
    logic [SEL_W-1:0] r_sel;
    logic             r_fault;
    logic [7:0]       r_count;

    // Walk from the highest index down so the lowest matching window wins on overlap.
    always_comb begin
        w_sel = SEL_NONE;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if (({1'b0, io_addr} >= {1'b0, SLAVE_BASE[i*32 +: 32]}) &&
                ({1'b0, io_addr} <  {1'b0, SLAVE_BASE[i*32 +: 32]} + {1'b0, SLAVE_SIZE[i*32 +: 32]}))
                w_sel = SEL_W'(i);
        end
    end

    always_comb begin
        s_addr = '0;
        s_op   = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            s_addr[i*32 +: 32] = io_addr - SLAVE_BASE[i*32 +: 32];
            s_op[i]            = io_op && (w_sel == SEL_W'(i));
        end
    end

    assign s_mask  = io_mask;
    assign s_wdata = io_wdata;
    assign w_fault = (io_ren || io_op) && (w_sel == SEL_NONE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sel   <= SEL_NONE;
            r_fault <= 1'b0;
            r_count <= 8'd0;
        end else begin
            if (io_ren)
                r_sel <= w_sel;
            r_fault <= w_fault;
            if (io_fault_clr)
                r_count <= {7'd0, w_fault};
            else if (w_fault && (r_count != 8'hFF))
                r_count <= r_count + 8'd1;
        end
    end

    // Slaves read synchronously, so the mux steers on the select registered with the request.
    always_comb begin
        io_rdata = UNMAPPED_RDATA;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (r_sel == SEL_W'(i))
                io_rdata = s_rdata[i*32 +: 32];
        end
    end

    assign io_fault       = r_fault;
    assign io_fault_count = r_count;

`ifdef DMEM_XBAR_FAULT_CAPTURE_EN
    logic [31:0] r_fault_addr;
    logic        r_fault_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fault_addr  <= 32'h0;
            r_fault_valid <= 1'b0;
        end else if (io_fault_clr) begin
            r_fault_addr  <= w_fault ? io_addr : 32'h0;
            r_fault_valid <= w_fault;
        end else if (w_fault && !r_fault_valid) begin
            r_fault_addr  <= io_addr;
            r_fault_valid <= 1'b1;
        end
    end

    assign io_fault_addr  = r_fault_addr;
    assign io_fault_valid = r_fault_valid;
`else
    assign io_fault_addr  = 32'h0;
    assign io_fault_valid = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_xbar.sv
// Directed self-checking bench for dmem_xbar with a small synchronous RAM model on slave 0.
module tb_dmem_xbar;

    logic        clk;
    logic        rst;
    logic [31:0] io_addr;
    logic        io_ren;
    logic        io_op;
    logic [3:0]  io_mask;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata;
    logic [95:0] s_addr;
    logic [2:0]  s_op;
    logic [3:0]  s_mask;
    logic [31:0] s_wdata;
    logic [95:0] s_rdata;
    logic        io_fault;
    logic [7:0]  io_fault_count;
    logic        io_fault_clr;
    logic [31:0] io_fault_addr;
    logic        io_fault_valid;

    int checks;
    int failures;

    logic [31:0] mem [16];
    logic [31:0] slv0_q;

    dmem_xbar dut (
        .clk(clk), .rst(rst), .io_addr(io_addr), .io_ren(io_ren), .io_op(io_op),
        .io_mask(io_mask), .io_wdata(io_wdata), .io_rdata(io_rdata), .s_addr(s_addr),
        .s_op(s_op), .s_mask(s_mask), .s_wdata(s_wdata), .s_rdata(s_rdata),
        .io_fault(io_fault), .io_fault_count(io_fault_count), .io_fault_clr(io_fault_clr),
        .io_fault_addr(io_fault_addr), .io_fault_valid(io_fault_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave 0: 16-word RAM with byte mask, synchronous read; slaves 1/2 return constants.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 16; k++) mem[k] <= 32'h5A000000 | k;
            slv0_q <= 32'h0;
        end else begin
            if (s_op[0])
                for (int b = 0; b < 4; b++)
                    if (s_mask[b]) mem[s_addr[5:2]][8*b +: 8] <= s_wdata[8*b +: 8];
            slv0_q <= mem[s_addr[5:2]];
        end
    end
    assign s_rdata = {32'hC2C2C2C2, 32'hA1A1A1A1, slv0_q};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        io_ren = 1'b0; io_op = 1'b0; io_fault_clr = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; idle(); io_addr = 32'h0; io_mask = 4'h0; io_wdata = 32'h0;
        #12;
        chk("reset_rdata", io_rdata, 32'hDEADBEEF);
        chk("reset_fault", {31'd0, io_fault}, 32'd0);
        chk("reset_count", {24'd0, io_fault_count}, 32'd0);
        chk("reset_faddr", io_fault_addr, 32'd0);
        chk("reset_fvalid", {31'd0, io_fault_valid}, 32'd0);
        #1 rst = 1'b1;
        step();
    endtask

    task automatic test_write_read();
        io_addr = 32'h08000010; io_op = 1'b1; io_wdata = 32'h12345678; io_mask = 4'hF;
        #1;
        chk("wr_s_op", {29'd0, s_op}, 32'h1);
        chk("wr_s_addr0", s_addr[31:0], 32'h10);
        chk("wr_s_addr1_wrap", s_addr[63:32], 32'hF7FF0010);
        chk("wr_s_wdata", s_wdata, 32'h12345678);
        step();
        io_op = 1'b0; io_ren = 1'b1;
        step();
        io_ren = 1'b0;
        chk("rd_after_wr", io_rdata, 32'h12345678);
        chk("rd_no_fault", {31'd0, io_fault}, 32'd0);
    endtask

    task automatic test_back_to_back();
        io_addr = 32'h10010000; io_ren = 1'b1;
        step();
        chk("b2b_slave1", io_rdata, 32'hA1A1A1A1);
        io_addr = 32'h08000004;
        step();
        io_ren = 1'b0;
        chk("b2b_slave0", io_rdata, 32'h5A000001);
    endtask

    task automatic test_boundary();
        io_addr = 32'h200000FC; io_op = 1'b1; io_mask = 4'h3;
        #1;
        chk("bnd_last_s_op", {29'd0, s_op}, 32'h4);
        chk("bnd_last_s_addr2", s_addr[95:64], 32'hFC);
        chk("bnd_s_mask", {28'd0, s_mask}, 32'h3);
        io_addr = 32'h20000100;
        #1;
        chk("bnd_past_s_op", {29'd0, s_op}, 32'h0);
        idle(); io_addr = 32'h08000000;
        step();
    endtask

    task automatic test_unmapped_read();
        io_addr = 32'h00000000; io_ren = 1'b1;
        step();
        io_ren = 1'b0; io_addr = 32'h08000000;
        chk("unm_rdata", io_rdata, 32'hDEADBEEF);
        chk("unm_fault", {31'd0, io_fault}, 32'd1);
        chk("unm_count", {24'd0, io_fault_count}, 32'd1);
`ifdef DMEM_XBAR_FAULT_CAPTURE_EN
        chk("unm_faddr", io_fault_addr, 32'h0);
        chk("unm_fvalid", {31'd0, io_fault_valid}, 32'd1);
`else
        chk("unm_fvalid", {31'd0, io_fault_valid}, 32'd0);
`endif
        step();
        chk("unm_pulse_end", {31'd0, io_fault}, 32'd0);
        chk("unm_count_hold", {24'd0, io_fault_count}, 32'd1);
    endtask

    task automatic test_saturate();
        int bad_op;
        bad_op = 0;
        io_op = 1'b1;
        for (int i = 0; i < 300; i++) begin
            io_addr = 32'h30000000 + 32'(i * 4);
            #1;
            if (s_op != 3'b000) bad_op++;
            step();
        end
        io_op = 1'b0;
        chk("sat_no_s_op", 32'(bad_op), 32'd0);
        chk("sat_count", {24'd0, io_fault_count}, 32'd255);
        chk("sat_fault_last", {31'd0, io_fault}, 32'd1);
        io_fault_clr = 1'b1; io_op = 1'b1; io_addr = 32'h40000000;
        step();
        idle(); io_addr = 32'h08000000;
        chk("clr_with_fault", {24'd0, io_fault_count}, 32'd1);
`ifdef DMEM_XBAR_FAULT_CAPTURE_EN
        chk("clr_capture_new", io_fault_addr, 32'h40000000);
`else
        chk("clr_capture_none", io_fault_addr, 32'h0);
`endif
        step();
        chk("clr_count_hold", {24'd0, io_fault_count}, 32'd1);
    endtask

    task automatic test_fault_capture();
        io_fault_clr = 1'b1;
        step();
        io_fault_clr = 1'b0;
        chk("cap_clr_count", {24'd0, io_fault_count}, 32'd0);
        chk("cap_clr_valid", {31'd0, io_fault_valid}, 32'd0);
        chk("cap_clr_addr", io_fault_addr, 32'd0);
        io_addr = 32'hFFFFFFFC; io_ren = 1'b1;
        step();
        io_addr = 32'h30000000;
        step();
        idle(); io_addr = 32'h08000000;
        chk("cap_count", {24'd0, io_fault_count}, 32'd2);
`ifdef DMEM_XBAR_FAULT_CAPTURE_EN
        chk("cap_first_addr", io_fault_addr, 32'hFFFFFFFC);
        chk("cap_valid", {31'd0, io_fault_valid}, 32'd1);
`else
        chk("cap_addr_tied", io_fault_addr, 32'h0);
        chk("cap_valid_tied", {31'd0, io_fault_valid}, 32'd0);
`endif
    endtask

    task automatic test_reset_mid_read();
        io_addr = 32'h08000000; io_ren = 1'b1;
        step();
        chk("mid_rdata_pre", io_rdata, 32'h5A000000);
        io_ren = 1'b0; io_op = 1'b1; io_addr = 32'h30000000;
        #2 rst = 1'b0;
        #1;
        chk("mid_rdata", io_rdata, 32'hDEADBEEF);
        chk("mid_count", {24'd0, io_fault_count}, 32'd0);
        chk("mid_faddr", io_fault_addr, 32'd0);
        chk("mid_fvalid", {31'd0, io_fault_valid}, 32'd0);
        step();
        chk("mid_fault_dropped", {31'd0, io_fault}, 32'd0);
        idle();
        #2 rst = 1'b1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_boundary();
        test_unmapped_read();
        test_saturate();
        test_fault_capture();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
